// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Optional build macro SEG_ARB_OWNER_TAG_EN is consumed by seg_display_arbiter.
package seg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seg_arb_state_t;

  localparam int DISP_W  = 16;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] IDLE_TAG = 4'hF;

endpackage

// File: rtl/seg_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_owner,
// scanning circularly; bits set in exclude_mask are never chosen.
module seg_arb_rr_pick
  import seg_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  input  logic [NREQ-1:0]  exclude_mask,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [NREQ-1:0]  eligible;
  logic [IDX_W-1:0] cand;

  assign eligible = req & ~exclude_mask;

  // Offset k=NREQ wraps back to last_owner itself, so it is considered last.
  always_comb begin
    pick  = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % NREQ);
      if (!any && eligible[cand]) begin
        any         = 1'b1;
        index       = cand;
        pick[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell per owner.
// Define SEG_ARB_OWNER_TAG_EN to show the owner index in the top digit (F when idle).
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [DISP_W-1:0]    disp_din,
  output logic                 busy,
  output logic                 dwell_done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam int IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  seg_arb_state_t   state_reg, state_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [IDX_W-1:0] last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [DISP_W-1:0] disp_reg, disp_next;
  logic             busy_reg, busy_next;
  logic             dwell_done_reg, dwell_done_next;

  logic [DISP_W-1:0] data_arr [NREQ];
  logic [DISP_W-1:0] owner_data;
  logic [DISP_W-1:0] shown;
  logic [DISP_W-1:0] idle_disp;

  logic [IDX_W-1:0] pick_last;
  logic [NREQ-1:0]  pick_excl;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[16*gi +: 16];
    end
  endgenerate

  assign owner_data = data_arr[owner_reg];

`ifdef SEG_ARB_OWNER_TAG_EN
  assign shown     = {{(DIGIT_W-IDX_W){1'b0}}, owner_reg, owner_data[DISP_W-DIGIT_W-1:0]};
  assign idle_disp = {IDLE_TAG, owner_data[DISP_W-DIGIT_W-1:0]};
`else
  assign shown     = owner_data;
  assign idle_disp = owner_data;
`endif

  // In HOLD the search starts after the current owner and skips it, so the
  // same picker serves both first grant and rotation/re-arbitration.
  assign pick_last = (state_reg == HOLD) ? owner_reg : last_owner_reg;
  assign pick_excl = (state_reg == HOLD) ? grant_reg : '0;

  seg_arb_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req          (req),
    .last_owner   (pick_last),
    .exclude_mask (pick_excl),
    .pick         (pick),
    .index        (pick_idx),
    .any          (pick_any)
  );

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    disp_next       = disp_reg;
    busy_next       = busy_reg;
    dwell_done_next = dwell_done_reg;

    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next      = HOLD;
          grant_next      = pick;
          owner_next      = pick_idx;
          cnt_next        = CNT_RELOAD;
          busy_next       = 1'b1;
          dwell_done_next = 1'b0;
        end
      end

      HOLD: begin
        disp_next = shown;
        if (!req[owner_reg]) begin
          // Owner released: hand over now regardless of dwell.
          last_owner_next = owner_reg;
          dwell_done_next = 1'b0;
          if (pick_any) begin
            grant_next = pick;
            owner_next = pick_idx;
            cnt_next   = CNT_RELOAD;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            busy_next  = 1'b0;
            cnt_next   = '0;
            disp_next  = idle_disp;
          end
        end else if (cnt_reg == '0) begin
          if (pick_any) begin
            last_owner_next = owner_reg;
            grant_next      = pick;
            owner_next      = pick_idx;
            cnt_next        = CNT_RELOAD;
            dwell_done_next = 1'b0;
          end else begin
            dwell_done_next = 1'b1;
          end
        end else begin
          cnt_next        = cnt_reg - 1'b1;
          dwell_done_next = (cnt_reg == CNT_W'(1));
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(NREQ - 1);
      cnt_reg        <= '0;
      disp_reg       <= '0;
      busy_reg       <= 1'b0;
      dwell_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
      disp_reg       <= disp_next;
      busy_reg       <= busy_next;
      dwell_done_reg <= dwell_done_next;
    end
  end

  assign grant      = grant_reg;
  assign disp_din   = disp_reg;
  assign busy       = busy_reg;
  assign dwell_done = dwell_done_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter (NREQ=4, DWELL_CYCLES=8); one line per transaction.
// Expected display values follow the SEG_ARB_OWNER_TAG_EN build when that macro is defined.
module tb_seg_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] d0, d1, d2, d3;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [15:0] disp_din;
  logic        busy;
  logic        dwell_done;

  int n_total;
  int n_pass;

  assign req_data = {d3, d2, d1, d0};

  seg_display_arbiter #(
    .NREQ         (4),
    .DWELL_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .disp_din   (disp_din),
    .busy       (busy),
    .dwell_done (dwell_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  g;
    logic        b;
    logic        dd;
    int          town;
    logic [15:0] dv;
  } vec_t;

  vec_t tbl [11];

  // town < 0: raw display value; otherwise the owner index shown in the tag build.
  function automatic logic [15:0] disp_of(int o, logic [15:0] d);
    if (o < 0) return d;
`ifdef SEG_ARB_OWNER_TAG_EN
    return {4'(o), d[11:0]};
`else
    return d;
`endif
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string tag, logic [3:0] g, logic b, logic [15:0] dv);
    check({tag, " grant"}, 16'(grant), 16'(g));
    check({tag, " busy"}, 16'(busy), 16'(b));
    check({tag, " disp"}, disp_din, dv);
    $display("%s: req=%b grant=%b busy=%b dwell=%b disp=%h", tag, req, grant, busy, dwell_done, disp_din);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    req = 4'b0000;
    d0 = 16'h0; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;

    // Table for the two-requester rotation (rows = state after each edge).
    tbl[0] = '{4'b0101, 4'b0001, 1'b1, 1'b0, -1, 16'h0000};
    for (int i = 1; i <= 7; i++)
      tbl[i] = '{4'b0101, 4'b0001, 1'b1, (i == 7), 0, 16'h1234};
    tbl[8]  = '{4'b0101, 4'b0100, 1'b1, 1'b0, 0, 16'h1234};
    tbl[9]  = '{4'b0101, 4'b0100, 1'b1, 1'b0, 2, 16'hABCD};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 15, 16'hABCD};

    #1;
    check_state("reset", 4'b0000, 1'b0, 16'h0000);
    check("reset dwell", 16'(dwell_done), 16'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Scenario 1: idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state($sformatf("idle%0d", i), 4'b0000, 1'b0, 16'h0000);
    end

    // Scenario 2: table-driven rotation between requesters 0 and 2.
    d0 = 16'h1234;
    d2 = 16'hABCD;
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      tick();
      check_state($sformatf("vec%0d", i), tbl[i].g, tbl[i].b, disp_of(tbl[i].town, tbl[i].dv));
      check($sformatf("vec%0d dwell", i), 16'(dwell_done), 16'(tbl[i].dd));
    end

    // Scenario 3: lone owner 1, live data update, holds past the dwell.
    d1 = 16'h0001;
    req = 4'b0010;
    tick();
    check_state("s3 grant", 4'b0010, 1'b1, disp_of(15, 16'hABCD));
    tick();
    check_state("s3 d1", 4'b0010, 1'b1, disp_of(1, 16'h0001));
    tick();
    d1 = 16'h0002;
    check_state("s3 lag", 4'b0010, 1'b1, disp_of(1, 16'h0001));
    tick();
    check_state("s3 d2", 4'b0010, 1'b1, disp_of(1, 16'h0002));
    for (int i = 0; i < 8; i++) tick();
    check_state("s3 beyond", 4'b0010, 1'b1, disp_of(1, 16'h0002));
    check("s3 dwell", 16'(dwell_done), 16'h1);
    req = 4'b0000;
    tick();
    check_state("s3 drop", 4'b0000, 1'b0, disp_of(15, 16'h0002));

    // Scenario 4: late request from 3 waits for owner 0's dwell to expire.
    d3 = 16'h3333;
    req = 4'b0001;
    tick();
    check_state("s4 grant", 4'b0001, 1'b1, disp_of(15, 16'h0002));
    tick();
    req = 4'b1001;
    for (int e = 3; e <= 8; e++) begin
      tick();
      check_state($sformatf("s4 e%0d", e), 4'b0001, 1'b1, disp_of(0, 16'h1234));
    end
    check("s4 dwell", 16'(dwell_done), 16'h1);
    tick();
    check_state("s4 switch", 4'b1000, 1'b1, disp_of(0, 16'h1234));
    req = 4'b0000;
    tick();
    check_state("s4 drop", 4'b0000, 1'b0, disp_of(15, 16'h3333));

    // Scenario 5: owner 2 drops early, nobody else waiting.
    d2 = 16'h5A5A;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    check_state("s5 hold", 4'b0100, 1'b1, disp_of(2, 16'h5A5A));
    req = 4'b0000;
    tick();
    check_state("s5 drop", 4'b0000, 1'b0, disp_of(15, 16'h5A5A));
    check("s5 dwell", 16'(dwell_done), 16'h0);
    tick();
    tick();
    check_state("s5 retain", 4'b0000, 1'b0, disp_of(15, 16'h5A5A));

    // Scenario 6: async reset mid-hold, then fresh arbitration starts at requester 0.
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    check_state("s6 hold", 4'b0001, 1'b1, disp_of(0, 16'h1234));
    #2;
    rst_n = 1'b0;
    #1;
    check_state("s6 async", 4'b0000, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    check_state("s6 regrant", 4'b0001, 1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
